// File: rtl/cache_pkg.sv
// Shared definitions for the main-memory port arbiter: default widths and
// the arbiter state encoding.
package cache_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_DONE = 2'b10,
      ST_WR   = 2'b11
   } arb_state_e;

endpackage

// File: rtl/main_mem_port_arbiter_if.sv
// Bundle of requester-side, memory-side and buffer-status signals of the
// main-memory port arbiter.
//
// Handshakes:
//  - store:  wr_req/wr_addr/wr_data presented by the requester; accepted in
//            the same cycle that wr_ack=1 (wr_ack = wr_req && !buf_full).
//  - refill: rd_req is a level held with a stable rd_addr until rd_done; the
//            one-cycle rd_done marks rd_data valid; rd_req drops in that cycle.
//  - memory: mem_read/mem_write with mem_addr/mem_wdata stay stable until the
//            one-cycle mem_ready pulse, which also qualifies mem_rdata.
interface main_mem_port_arbiter_if
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_done;
   logic [DATA_W-1:0] rd_data;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              buf_full;
   logic              buf_empty;
   logic [CNT_W-1:0]  buf_count;

   // Arbiter view.
   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_ready,
      output wr_ack, rd_done, rd_data, mem_read, mem_write, mem_addr, mem_wdata,
             buf_full, buf_empty, buf_count
   );

   // Requester / memory-model view.
   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_ready,
      input  wr_ack, rd_done, rd_data, mem_read, mem_write, mem_addr, mem_wdata,
             buf_full, buf_empty, buf_count
   );

endinterface

// File: rtl/write_buffer_fifo.sv
// In-order write buffer for write-through stores. Also compares a read
// address against every occupied entry to flag a read-after-write hazard.
module write_buffer_fifo
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   input  logic              chk_valid,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              hazard,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] entry_addr [DEPTH];
   logic [DATA_W-1:0] entry_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Storage is not reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         entry_addr[wr_ptr] <= push_addr;
         entry_data[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign head_addr = entry_addr[rd_ptr];
   assign head_data = entry_data[rd_ptr];

   // Entry i is live when its distance from the head is below the count.
   always_comb begin
      logic [PTR_W-1:0] offs;
      hazard = 1'b0;
      offs   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PTR_W'(i) - rd_ptr;
         if (chk_valid && (CNT_W'(offs) < count) && (entry_addr[i] == chk_addr))
            hazard = 1'b1;
      end
   end

endmodule

// File: rtl/main_mem_port_arbiter.sv
// Owns the single main-memory port: refill reads go ahead of buffered
// write-through stores unless they hit an address still in the buffer.
module main_mem_port_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   main_mem_port_arbiter_if.slave bus,
   output arb_state_e             dbg_state
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic              push;
   logic              pop;
   logic              hazard;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   // Full is the registered count, so a pop in the same cycle does not help.
   assign push       = bus.wr_req && !bus.buf_full;
   assign pop        = (state_q == ST_WR) && bus.mem_ready;
   assign bus.wr_ack = push;

   write_buffer_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_wbuf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (bus.wr_addr),
      .push_data (bus.wr_data),
      .pop       (pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .chk_valid (bus.rd_req),
      .chk_addr  (bus.rd_addr),
      .hazard    (hazard),
      .full      (bus.buf_full),
      .empty     (bus.buf_empty),
      .count     (bus.buf_count)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: a full buffer drains first, then non-conflicting reads,
   // then any remaining writes (which also clears a hazard in order).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.buf_full)                 state_d = ST_WR;
            else if (bus.rd_req && !hazard)   state_d = ST_RD;
            else if (!bus.buf_empty)          state_d = ST_WR;
         end
         ST_RD:   if (bus.mem_ready) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         ST_WR:   if (bus.mem_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Refill address is captured when the read is granted.
   always_ff @(posedge clk) begin
      if (reset)                                      rd_addr_q <= '0;
      else if (state_q == ST_IDLE && state_d == ST_RD) rd_addr_q <= bus.rd_addr;
   end

   // Read word is captured on completion and held until the next refill.
   always_ff @(posedge clk) begin
      if (reset)                                 rd_data_q <= '0;
      else if (state_q == ST_RD && bus.mem_ready) rd_data_q <= bus.mem_rdata;
   end

   // Moore memory-port outputs; address and data are zero when idle.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_RD: begin
            mem_read = 1'b1;
            mem_addr = rd_addr_q;
         end
         ST_WR: begin
            mem_write = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
         end
         default: ;
      endcase
   end

   assign bus.mem_read  = mem_read;
   assign bus.mem_write = mem_write;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.rd_done   = (state_q == ST_DONE);
   assign bus.rd_data   = rd_data_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_main_mem_port_arbiter.sv
// Directed bench for the main-memory port arbiter. Inputs change 1 time unit
// after the rising edge; outputs are checked 2 units after it.
module tb_main_mem_port_arbiter;
   import cache_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   arb_state_e dbg_state;
   int         vectors = 0;
   int         miscompares = 0;

   main_mem_port_arbiter_if bus ();

   main_mem_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   // Requester rule and exclusive strobes, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(bus.wr_req && bus.rd_req)) else begin
            miscompares++;
            $error("FAIL req_rule wr_req=%0b rd_req=%0b required not both 1", bus.wr_req, bus.rd_req);
         end
         assert (!(bus.mem_read && bus.mem_write)) else begin
            miscompares++;
            $error("FAIL strobe_excl mem_read=%0b mem_write=%0b required not both 1", bus.mem_read, bus.mem_write);
         end
      end
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push(input logic [9:0] a, input logic [31:0] d);
      bus.wr_req  = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
   endtask

   task automatic mem_resp(input logic rdy, input logic [31:0] d);
      bus.mem_ready = rdy;
      bus.mem_rdata = d;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_req = 0; bus.rd_addr = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;

      // Reset state
      repeat (3) step();
      reset = 1'b0;
      settle();
      chk("rst_state", dbg_state, ST_IDLE);
      chk("rst_count", bus.buf_count, 0);
      chk("rst_empty", bus.buf_empty, 1);
      chk("rst_full", bus.buf_full, 0);
      chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.rd_done}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rd_data", bus.rd_data, 0);

      // 1: read with empty buffer, mem_ready in the 3rd RD cycle
      step(); bus.rd_req = 1; bus.rd_addr = 10'h155; settle();
      chk("t1_idle", dbg_state, ST_IDLE);
      step(); settle();
      chk("t1_rd_state", dbg_state, ST_RD);
      chk("t1_mem_read", bus.mem_read, 1);
      chk("t1_mem_addr", bus.mem_addr, 10'h155);
      step(); settle();
      chk("t1_rd_wait", dbg_state, ST_RD);
      step(); mem_resp(1, 32'hDEAD_BEEF); settle();
      chk("t1_rd_hold_addr", bus.mem_addr, 10'h155);
      step(); mem_resp(0, 0); bus.rd_req = 0; settle();
      chk("t1_done", bus.rd_done, 1);
      chk("t1_rd_data", bus.rd_data, 32'hDEAD_BEEF);
      step(); settle();
      chk("t1_done_pulse", bus.rd_done, 0);
      chk("t1_back_idle", dbg_state, ST_IDLE);
      chk("t1_rd_data_held", bus.rd_data, 32'hDEAD_BEEF);

      // 2: two stores drain in order
      step(); push(10'h010, 32'hA); settle();
      chk("t2_ack0", bus.wr_ack, 1);
      step(); push(10'h020, 32'hB); settle();
      chk("t2_ack1", bus.wr_ack, 1);
      chk("t2_cnt1", bus.buf_count, 1);
      step(); bus.wr_req = 0; mem_resp(1, 0); settle();
      chk("t2_cnt2", bus.buf_count, 2);
      chk("t2_wr0_state", dbg_state, ST_WR);
      chk("t2_wr0_addr", bus.mem_addr, 10'h010);
      chk("t2_wr0_data", bus.mem_wdata, 32'hA);
      step(); mem_resp(0, 0); settle();
      chk("t2_gap_idle", dbg_state, ST_IDLE);
      chk("t2_cnt_after0", bus.buf_count, 1);
      step(); mem_resp(1, 0); settle();
      chk("t2_wr1_addr", bus.mem_addr, 10'h020);
      chk("t2_wr1_data", bus.mem_wdata, 32'hB);
      step(); mem_resp(0, 0); settle();
      chk("t2_cnt_end", bus.buf_count, 0);
      step(); settle();
      chk("t2_stay_idle", {bus.mem_write, bus.mem_read}, 0);

      // 3: read bypasses a non-conflicting buffered store
      step(); push(10'h030, 32'hC); settle();
      step(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 10'h040; settle();
      chk("t3_cnt", bus.buf_count, 1);
      step(); mem_resp(1, 32'h1234_5678); settle();
      chk("t3_rd_first", dbg_state, ST_RD);
      chk("t3_rd_addr", bus.mem_addr, 10'h040);
      step(); mem_resp(0, 0); bus.rd_req = 0; settle();
      chk("t3_rd_data", bus.rd_data, 32'h1234_5678);
      step(); settle();
      chk("t3_cnt_kept", bus.buf_count, 1);
      step(); mem_resp(1, 0); settle();
      chk("t3_wr_after", dbg_state, ST_WR);
      chk("t3_wr_addr", bus.mem_addr, 10'h030);
      step(); mem_resp(0, 0); settle();
      chk("t3_cnt_end", bus.buf_count, 0);

      // 4: conflicting read waits for both entries to drain
      step(); push(10'h050, 32'h5); settle();
      step(); push(10'h060, 32'h6); settle();
      step(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 10'h060; mem_resp(1, 0); settle();
      chk("t4_wr0_addr", bus.mem_addr, 10'h050);
      step(); mem_resp(0, 0); settle();
      chk("t4_idle_cnt1", bus.buf_count, 1);
      step(); mem_resp(1, 0); settle();
      chk("t4_hazard_wr", dbg_state, ST_WR);
      chk("t4_wr1_addr", bus.mem_addr, 10'h060);
      step(); mem_resp(0, 0); settle();
      chk("t4_cnt0", bus.buf_count, 0);
      chk("t4_no_read_yet", bus.mem_read, 0);
      step(); mem_resp(1, 32'h0BAD_F00D); settle();
      chk("t4_rd_state", dbg_state, ST_RD);
      chk("t4_rd_addr", bus.mem_addr, 10'h060);
      step(); mem_resp(0, 0); bus.rd_req = 0; settle();
      chk("t4_rd_data", bus.rd_data, 32'h0BAD_F00D);
      step(); settle();

      // 5: fill to full, refused push, full beats a non-hazard read
      step(); push(10'h100, 32'hD0); settle();
      step(); push(10'h104, 32'hD1); settle();
      step(); push(10'h108, 32'hD2); settle();
      step(); push(10'h10C, 32'hD3); settle();
      chk("t5_ack3", bus.wr_ack, 1);
      step(); push(10'h110, 32'hD4); settle();
      chk("t5_full", bus.buf_full, 1);
      chk("t5_ack_refused", bus.wr_ack, 0);
      step(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 10'h200; mem_resp(1, 0); settle();
      chk("t5_cnt_still4", bus.buf_count, 4);
      chk("t5_pop_addr", bus.mem_addr, 10'h100);
      step(); mem_resp(0, 0); settle();
      chk("t5_cnt3", bus.buf_count, 3);
      step(); mem_resp(1, 32'hCAFE_0001); settle();
      chk("t5_rd_state", dbg_state, ST_RD);
      step(); mem_resp(0, 0); bus.rd_req = 0; push(10'h110, 32'hD4); settle();
      chk("t5_done_ack", bus.wr_ack, 1);
      chk("t5_rd_data", bus.rd_data, 32'hCAFE_0001);
      step(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = 10'h204; settle();
      chk("t5_idle_full", bus.buf_full, 1);
      step(); mem_resp(1, 0); settle();
      chk("t5_full_wins", dbg_state, ST_WR);
      chk("t5_full_rd_off", bus.mem_read, 0);
      chk("t5_full_head", bus.mem_addr, 10'h104);
      step(); mem_resp(0, 0); settle();
      step(); mem_resp(1, 32'hCAFE_0002); settle();
      chk("t5_rd2_addr", bus.mem_addr, 10'h204);
      step(); mem_resp(0, 0); bus.rd_req = 0; settle();
      chk("t5_rd2_data", bus.rd_data, 32'hCAFE_0002);
      step(); settle();

      // 6a: reset in WR with three entries, then a late mem_ready
      step(); settle();
      chk("t6_wr_state", dbg_state, ST_WR);
      chk("t6_cnt3", bus.buf_count, 3);
      chk("t6_wr_head", bus.mem_addr, 10'h108);
      reset = 1'b1;
      step(); reset = 1'b0; mem_resp(1, 32'h7777_7777); settle();
      chk("t6_wr_rst_state", dbg_state, ST_IDLE);
      chk("t6_wr_rst_cnt", bus.buf_count, 0);
      chk("t6_wr_rst_strobes", {bus.mem_read, bus.mem_write, bus.rd_done}, 0);
      chk("t6_wr_rst_addr", bus.mem_addr, 0);
      step(); mem_resp(0, 0); settle();
      chk("t6_late_ignored", dbg_state, ST_IDLE);
      chk("t6_rd_data_rst", bus.rd_data, 0);

      // 6b: reset in RD, then a late mem_ready
      step(); bus.rd_req = 1; bus.rd_addr = 10'h155; settle();
      step(); settle();
      chk("t6_rd_state", dbg_state, ST_RD);
      reset = 1'b1; bus.rd_req = 0;
      step(); reset = 1'b0; mem_resp(1, 32'h8888_8888); settle();
      chk("t6_rd_rst_state", dbg_state, ST_IDLE);
      chk("t6_rd_rst_read", bus.mem_read, 0);
      step(); mem_resp(0, 0); settle();
      chk("t6_rd_late_state", dbg_state, ST_IDLE);
      chk("t6_rd_late_done", bus.rd_done, 0);
      chk("t6_rd_late_data", bus.rd_data, 0);

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
